// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: stalls the pipeline for LATENCY cycles per
// access, then performs one load or store and presents the result in the DONE cycle.
module dmem_responder #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             MEM_READ_M,
    input  logic             MEM_WRITE_M,
    input  logic [WIDTH-1:0] ADDR_M,
    input  logic [WIDTH-1:0] WRITE_DATA_M,
    output logic [WIDTH-1:0] MEM_RD_M,
    output logic             STALL_M,
    output logic             MEM_ERR_M
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             op_write;
    logic             op_fault;
    logic [AW-1:0]    idx_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rd_q;
    logic             err_q;

    // NOTE: the array has no reset; CLR leaves contents alone, and the declaration
    // initialiser only provides the time-0 zero image.
    logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic             req;
    logic             fault;
    logic             fire;
    logic             acc_write;
    logic             acc_fault;
    logic [AW-1:0]    acc_idx;
    logic [WIDTH-1:0] acc_wdata;

    assign req   = MEM_READ_M | MEM_WRITE_M;
    assign fault = (ADDR_M[1:0] != 2'b00)
                 || ((ADDR_M >> 2) >= WIDTH'(DEPTH))
                 || (MEM_READ_M && MEM_WRITE_M);

    // With LATENCY==1 the access fires on the request edge, so it uses live inputs.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        acc_write = op_write;
        acc_fault = op_fault;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        fire      = 1'b0;
        if (state == IDLE) begin
            acc_write = MEM_WRITE_M;
            acc_fault = fault;
            acc_idx   = ADDR_M[AW+1:2];
            acc_wdata = WRITE_DATA_M;
            fire      = req && (LATENCY == 1);
        end else if (state == BUSY) begin
            fire      = req && (cnt == CW'(1));
        end
    end

    always_ff @(posedge CLK) begin
        if (fire && !CLR && acc_write && !acc_fault) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= IDLE;
            cnt      <= '0;
            op_write <= 1'b0;
            op_fault <= 1'b0;
            idx_q    <= '0;
            wdata_q  <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            rd_q  <= '0;
            err_q <= 1'b0;
            if (fire) begin
                rd_q  <= (!acc_write && !acc_fault) ? mem[acc_idx] : '0;
                err_q <= acc_fault;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        op_write <= MEM_WRITE_M;
                        op_fault <= fault;
                        idx_q    <= ADDR_M[AW+1:2];
                        wdata_q  <= WRITE_DATA_M;
                        cnt      <= CW'(LATENCY - 1);
                        state    <= (LATENCY == 1) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state <= IDLE;
                    end else if (cnt == CW'(1)) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign STALL_M   = (state == BUSY) || ((state == IDLE) && req && !CLR);
    assign MEM_RD_M  = rd_q;
    assign MEM_ERR_M = err_q;

endmodule
